// File: rtl/nabp_mapper_sweep.sv
// Mapper sweep stage: presents one angle to the mapper LUT, waits out its latency, then emits
// NUM_STEPS line-buffer addresses. Define NABP_MAPPER_ROUND_EN for round-half-up address mapping.
module nabp_mapper_sweep #(
  parameter int ANGLE_WIDTH = 8,
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_STEPS   = 256,
  parameter int LUT_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   angle_valid,
  output logic                   angle_ready,
  output logic [ANGLE_WIDTH-1:0] lut_angle,
  input  logic [FIXED_WIDTH-1:0] lut_accu_part,
  input  logic [FIXED_WIDTH-1:0] lut_accu_base,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   addr_oob,
  output logic                   addr_last,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   angle_error
);

  localparam int STEP_WIDTH = $clog2(NUM_STEPS);
  localparam int ACC_WIDTH  = FIXED_WIDTH + STEP_WIDTH + 1;
  localparam int LAT_WIDTH  = $clog2(LUT_LATENCY + 1);
`ifdef NABP_MAPPER_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(2 ** (FRAC_BITS - 1));
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t                        state_r;
  logic signed [ACC_WIDTH-1:0]   acc_r;
  logic [STEP_WIDTH-1:0]         step_r;
  logic [LAT_WIDTH-1:0]          lat_cnt_r;

  logic signed [ACC_WIDTH-1:0]   base_ext_s;
  logic signed [ACC_WIDTH-1:0]   part_ext_s;
  logic signed [ACC_WIDTH-1:0]   acc_next_s;
  logic [STEP_WIDTH-1:0]         step_next_s;
  logic [ADDR_WIDTH:0]           map_base_s;
  logic [ADDR_WIDTH:0]           map_next_s;

  // Maps an accumulator value to {oob, addr}; out-of-range integer parts give addr 0.
  function automatic logic [ADDR_WIDTH:0] map_addr(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] int_v;
    logic                        oob_v;
`ifdef NABP_MAPPER_ROUND_EN
    int_v = (acc + HALF_LSB) >>> FRAC_BITS;
`else
    int_v = acc >>> FRAC_BITS;
`endif
    oob_v = int_v[ACC_WIDTH-1] | (|int_v[ACC_WIDTH-2:ADDR_WIDTH]);
    return {oob_v, oob_v ? {ADDR_WIDTH{1'b0}} : int_v[ADDR_WIDTH-1:0]};
  endfunction

  // Next accumulator/step values and their mapped addresses, so outputs can be registered.
  always_comb begin
    base_ext_s  = {{(ACC_WIDTH-FIXED_WIDTH){lut_accu_base[FIXED_WIDTH-1]}}, lut_accu_base};
    part_ext_s  = {{(ACC_WIDTH-FIXED_WIDTH){lut_accu_part[FIXED_WIDTH-1]}}, lut_accu_part};
    acc_next_s  = acc_r + part_ext_s;
    step_next_s = step_r + STEP_WIDTH'(1);
    map_base_s  = map_addr(base_ext_s);
    map_next_s  = map_addr(acc_next_s);
  end

  // Sweep FSM with registered handshake and address outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      step_r      <= '0;
      lat_cnt_r   <= '0;
      angle_ready <= 1'b1;
      lut_angle   <= '0;
      addr        <= '0;
      addr_oob    <= 1'b0;
      addr_last   <= 1'b0;
      addr_valid  <= 1'b0;
      angle_error <= 1'b0;
    end else begin
      angle_error <= 1'b0;
      case (state_r)
        IDLE: begin
          if (angle_valid) begin
            if (angle < ANGLE_WIDTH'(180)) begin
              lut_angle   <= angle;
              lat_cnt_r   <= '0;
              angle_ready <= 1'b0;
              state_r     <= LOOKUP;
            end else begin
              angle_error <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          // LUT outputs for lut_angle are settled once LUT_LATENCY cycles have elapsed.
          if (lat_cnt_r == LAT_WIDTH'(LUT_LATENCY)) begin
            acc_r      <= base_ext_s;
            step_r     <= '0;
            addr       <= map_base_s[ADDR_WIDTH-1:0];
            addr_oob   <= map_base_s[ADDR_WIDTH];
            addr_last  <= 1'b0;
            addr_valid <= 1'b1;
            state_r    <= EMIT;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_WIDTH'(1);
          end
        end
        EMIT: begin
          if (addr_ready) begin
            if (addr_last) begin
              addr_valid  <= 1'b0;
              addr        <= '0;
              addr_oob    <= 1'b0;
              addr_last   <= 1'b0;
              angle_ready <= 1'b1;
              state_r     <= IDLE;
            end else begin
              acc_r     <= acc_next_s;
              step_r    <= step_next_s;
              addr      <= map_next_s[ADDR_WIDTH-1:0];
              addr_oob  <= map_next_s[ADDR_WIDTH];
              addr_last <= (step_next_s == STEP_WIDTH'(NUM_STEPS - 1));
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          angle_ready <= 1'b1;
          addr_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nabp_mapper_sweep.sv
// Scoreboard bench for nabp_mapper_sweep: a 2-cycle LUT model feeds the DUT, expected
// addresses are queued per sweep and checked by an independent handshake monitor.
module tb_nabp_mapper_sweep;

  typedef struct packed {
    logic [8:0] addr;
    logic       oob;
    logic       last;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  angle;
  logic        angle_valid;
  logic        angle_ready;
  logic [7:0]  lut_angle;
  logic [15:0] lut_accu_part;
  logic [15:0] lut_accu_base;
  logic [8:0]  addr;
  logic        addr_oob;
  logic        addr_last;
  logic        addr_valid;
  logic        addr_ready;
  logic        angle_error;

  logic [7:0]  lut_p1, lut_p2;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cap_cnt = 0;
  int          last_hs_cyc = 0;
  int          first_cyc = 0;
  logic [8:0]  cap_addr[512];
  logic        cap_oob[512];
  logic        stall_pending = 1'b0;
  logic [8:0]  prev_addr = 9'd0;

  nabp_mapper_sweep dut (
    .clk(clk), .reset(reset), .angle(angle), .angle_valid(angle_valid),
    .angle_ready(angle_ready), .lut_angle(lut_angle), .lut_accu_part(lut_accu_part),
    .lut_accu_base(lut_accu_base), .addr(addr), .addr_oob(addr_oob), .addr_last(addr_last),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .angle_error(angle_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mapper LUT contents used by this bench: {base, part}.
  task automatic lut_lookup(input logic [7:0] a, output logic [15:0] b, output logic [15:0] p);
    case (a)
      8'd0:    begin b = 16'h0000; p = 16'h0100; end
      8'd45:   begin b = 16'h0080; p = 16'h0080; end
      8'd90:   begin b = 16'h0200; p = 16'hFF00; end
      8'd10:   begin b = 16'h0400; p = 16'h0040; end
      8'd20:   begin b = 16'h0100; p = 16'h0100; end
      default: begin b = 16'h0000; p = 16'h0000; end
    endcase
  endtask

  // LUT model with two register stages of latency.
  always @(posedge clk) begin
    lut_p1 <= lut_angle;
    lut_p2 <= lut_p1;
  end
  always_comb lut_lookup(lut_p2, lut_accu_base, lut_accu_part);

  function automatic exp_t model(input logic [15:0] b, input logic [15:0] p, input int k);
    int   acc;
    int   iv;
    exp_t e;
    acc = int'($signed(b)) + k * int'($signed(p));
`ifdef NABP_MAPPER_ROUND_EN
    acc = acc + 128;
`endif
    iv = acc >>> 8;
    e.oob  = (iv < 0) || (iv > 511);
    e.addr = e.oob ? 9'd0 : iv[8:0];
    e.last = (k == 255);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted address against the scoreboard, and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending && addr_valid) check("stall_hold", addr, prev_addr);
      stall_pending = addr_valid && !addr_ready;
      prev_addr = addr;
      if (addr_valid && addr_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("addr", addr, e.addr);
          check("addr_oob", addr_oob, e.oob);
          check("addr_last", addr_last, e.last);
        end
        if (cap_cnt < 512) begin
          cap_addr[cap_cnt] = addr;
          cap_oob[cap_cnt] = addr_oob;
        end
        cap_cnt++;
        if (addr_last) last_hs_cyc = cyc;
      end
    end
  end

  task automatic push_sweep(input logic [7:0] a);
    logic [15:0] b, p;
    lut_lookup(a, b, p);
    for (int k = 0; k < 256; k++) exp_q.push_back(model(b, p, k));
    cap_cnt = 0;
  endtask

  // Full sweep from IDLE; entered and left at #1 after a rising edge.
  task automatic run_sweep(input logic [7:0] a, input bit toggle);
    int lat;
    int n;
    push_sweep(a);
    addr_ready = !toggle;
    angle = a;
    angle_valid = 1'b1;
    @(posedge clk); #1;
    angle_valid = 1'b0;
    check("accept_ready_low", angle_ready, 0);
    check("lut_angle", lut_angle, a);
    lat = 0;
    while (!addr_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", lat, 3);
    first_cyc = cyc;
    if (toggle) addr_ready = 1'b1;
    n = 0;
    while (!angle_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (toggle) addr_ready = !addr_ready;
    end
    check("sweep_done", angle_ready, 1);
    check("ready_after_last", cyc, last_hs_cyc + 1);
    check("handshakes", cap_cnt, 256);
    check("queue_drained", exp_q.size(), 0);
    check("valid_low_idle", addr_valid, 0);
    if (toggle) check("toggle_span", last_hs_cyc + 1 - first_cyc, 511);
    addr_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] hand[5];
    bit         seen_valid;
    int         n;
    reset = 1'b1;
    angle = 8'd0;
    angle_valid = 1'b0;
    addr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_angle_ready", angle_ready, 1);
    check("rst_lut_angle", lut_angle, 0);
    check("rst_addr", addr, 0);
    check("rst_addr_oob", addr_oob, 0);
    check("rst_addr_last", addr_last, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_angle_error", angle_error, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Unit slope from zero.
    run_sweep(8'd0, 1'b0);
    check("a0_addr100", cap_addr[100], 100);
    check("a0_addr255", cap_addr[255], 255);

    // Half slope from half offset.
`ifdef NABP_MAPPER_ROUND_EN
    hand = '{9'd1, 9'd1, 9'd2, 9'd2, 9'd3};
`else
    hand = '{9'd0, 9'd1, 9'd1, 9'd2, 9'd2};
`endif
    run_sweep(8'd45, 1'b0);
    for (int i = 0; i < 5; i++) check("a45_head", cap_addr[i], hand[i]);
    check("a45_tail", cap_addr[255], 128);

    // Negative slope running below zero.
    run_sweep(8'd90, 1'b0);
    check("a90_s0", cap_addr[0], 2);
    check("a90_s1", cap_addr[1], 1);
    check("a90_s2", cap_addr[2], 0);
    check("a90_oob2", cap_oob[2], 0);
    check("a90_oob3", cap_oob[3], 1);
    check("a90_addr3", cap_addr[3], 0);
    check("a90_oob255", cap_oob[255], 1);

    // Rejected angle.
    angle = 8'd180;
    angle_valid = 1'b1;
    @(posedge clk); #1;
    angle_valid = 1'b0;
    check("err_pulse", angle_error, 1);
    check("err_lut_angle", lut_angle, 90);
    check("err_ready", angle_ready, 1);
    seen_valid = addr_valid;
    @(posedge clk); #1;
    check("err_single", angle_error, 0);
    repeat (4) begin
      seen_valid |= addr_valid;
      @(posedge clk); #1;
    end
    check("err_no_valid", seen_valid, 0);
    check("err_lut_angle_kept", lut_angle, 90);
    run_sweep(8'd10, 1'b0);

    // Backpressure every other cycle.
    run_sweep(8'd0, 1'b1);
    check("tog_addr128", cap_addr[128], 128);

    // Reset mid-sweep at step 100.
    push_sweep(8'd20);
    addr_ready = 1'b1;
    angle = 8'd20;
    angle_valid = 1'b1;
    @(posedge clk); #1;
    angle_valid = 1'b0;
    n = 0;
    while (cap_cnt < 100 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_step", cap_cnt, 100);
    check("abort_valid_before", addr_valid, 1);
    reset = 1'b1;
    #1;
    check("abort_valid_low", addr_valid, 0);
    check("abort_ready_high", angle_ready, 1);
    check("abort_addr", addr, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_after", angle_ready, 1);
    run_sweep(8'd20, 1'b0);
    check("restart_s0", cap_addr[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nabp_mapper_sweep.md
Name: nabp_mapper_sweep

Overview:
- Consumer stage directly downstream of the mapper look-up table.
- Accepts one projection angle per sweep and drives that angle to the LUT.
- Waits out the LUT's fixed 2-cycle latency, then accumulates the returned per-step slope (accu_part) onto the start offset (accu_base).
- Emits NUM_STEPS line-buffer addresses, one per valid/ready handshake, to the projection line buffer.

Parameters:
ANGLE_WIDTH, 8, angle code width; legal angles 0..179.
FIXED_WIDTH, 16, width of accu_part/accu_base, two's-complement signed fixed point.
FRAC_BITS, 8, fractional bits in accu_part/accu_base.
ADDR_WIDTH, 9, line-buffer address width.
NUM_STEPS, 256, addresses emitted per sweep (>=2).
LUT_LATENCY, 2, cycles from lut_angle change to valid LUT outputs.

Ports:
clk  in  1  clock; all state on posedge.
reset  in  1  asynchronous, active-high reset.
angle  in  ANGLE_WIDTH  requested projection angle.
angle_valid  in  1  angle request valid.
angle_ready  out  1  high only in IDLE.
lut_angle  out  ANGLE_WIDTH  angle presented to the mapper LUT (registered).
lut_accu_part  in  FIXED_WIDTH  signed per-step increment from the LUT.
lut_accu_base  in  FIXED_WIDTH  signed start offset from the LUT.
addr  out  ADDR_WIDTH  mapped line-buffer address.
addr_oob  out  1  current address is outside 0..2^ADDR_WIDTH-1.
addr_last  out  1  current address is step NUM_STEPS-1.
addr_valid  out  1  addr/addr_oob/addr_last valid.
addr_ready  in  1  line buffer accepts the address.
angle_error  out  1  one-cycle pulse for a rejected angle (>=180).

Behaviour:
- Reset values: state IDLE; angle_ready 1; lut_angle 0; addr 0; addr_oob 0; addr_last 0; addr_valid 0; angle_error 0. Internal accumulator and step counter are 0.
- Reset asserted mid-sweep aborts the sweep at once, with no further addresses. Any un-accepted address is discarded.
- Accumulator: ACC_WIDTH = FIXED_WIDTH + clog2(NUM_STEPS) + 1, sign-extended. It never wraps across a full sweep.
- FSM states:
  - IDLE: angle_ready=1. On angle_valid&&angle_ready:
    - angle<180: lut_angle<=angle, latency counter cleared, go to LOOKUP.
    - angle>=180: angle_error pulses for 1 cycle, lut_angle unchanged, stay in IDLE.
  - LOOKUP: angle_ready=0. Counts LUT_LATENCY cycles. On the cycle the count completes:
    - acc<=sext(lut_accu_base), step<=0, go to EMIT.
    - Latency from accept to first addr_valid = LUT_LATENCY+1 cycles (3 at default).
  - EMIT: addr_valid=1.
    - addr/addr_oob/addr_last are derived from registered acc/step and held stable while addr_ready=0.
    - On handshake: acc<=acc+sext(lut_accu_part), step<=step+1.
    - On the handshake with addr_last=1: addr_valid<=0, go to IDLE. angle_ready is high the next cycle, so there is no back-to-back overlap and sustained throughput is 1 address/cycle within a sweep.
- lut_angle stays constant through LOOKUP and EMIT, so LUT outputs stay stable for the whole sweep.
- Address derivation: int = acc >>> FRAC_BITS (floor).
  - int<0 or int>2^ADDR_WIDTH-1: addr_oob=1 and addr=0.
  - Otherwise addr=int[ADDR_WIDTH-1:0].
  - Out-of-range steps are still emitted and still consume a handshake.
- addr_last = (step==NUM_STEPS-1).
- angle_valid in any state other than IDLE is ignored: no queue, no error.

Optional Feature:
- Macro: NABP_MAPPER_ROUND_EN.
- Defined: int = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up. The rounded value is used for both addr and the addr_oob check.
- Undefined: floor (truncation toward -inf) as above. No extra adder or logic is present.

Test Plan:
- Reset, then angle=0 with lut_accu_base=0x0000 and lut_accu_part=0x0100 (1.0) -> first addr_valid 3 cycles after accept; addr 0,1,...,255; addr_last only on 255; angle_ready returns the cycle after the last handshake.
- angle=45 with base=0x0080 (0.5) and part=0x0080 (0.5), addr_ready always 1 -> floor: 0,1,1,2,2,...; with NABP_MAPPER_ROUND_EN: 1,1,2,2,3,...
- base=0x0200 (2.0), part=0xFF00 (-1.0) -> addr 2,1,0; then addr_oob=1 with addr=0 for steps 3..255; 256 handshakes total.
- Toggle addr_ready 1/0 each cycle during a part=1.0 sweep -> addr holds while ready=0; no skipped or duplicated values; sweep takes 511 cycles from first valid.
- angle=180 in IDLE -> angle_error is a single-cycle pulse; lut_angle unchanged; no addr_valid; next angle=10 is accepted normally.
- Assert reset at step 100 with addr_valid=1 -> addr_valid drops to 0 immediately; after release angle_ready=1 and a new sweep restarts at step 0.
